// File: rtl/stopwatch_core.sv
// Centisecond BCD stopwatch (mm:ss.cc) counting rising edges of a divided tick.
// Run/pause, clear and lap-hold controls; saturates at MAX_MIN:59.99.
module stopwatch_core #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] cs_bcd,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    FULL
  } state_e;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);
  localparam logic [23:0] CNT_MAX =
    {MAX_T, MAX_O, 4'd5, 4'd9, 4'd9, 4'd9};

  state_e      state_q, state_d;
  logic        tick_q;
  logic        tick_rise;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] lap_q, lap_d;
  logic        hold_q, hold_d;
  logic [23:0] disp_q;
  logic        run_q, ovf_q;

  // Packed as {min_t, min_o, sec_t, sec_o, cs_t, cs_o}.
  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    r = c;
    if (c[3:0] != 4'd9) begin
      r[3:0] = c[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd9) begin
        r[7:4] = c[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) begin
          r[11:8] = c[11:8] + 4'd1;
        end else begin
          r[11:8] = 4'd0;
          if (c[15:12] != 4'd5) begin
            r[15:12] = c[15:12] + 4'd1;
          end else begin
            r[15:12] = 4'd0;
            if (c[19:16] != 4'd9) begin
              r[19:16] = c[19:16] + 4'd1;
            end else begin
              r[19:16] = 4'd0;
              r[23:20] = c[23:20] + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  assign tick_rise = tick_in & ~tick_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    hold_d  = hold_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      lap_d   = '0;
      hold_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_stop) state_d = RUN;
        end
        RUN: begin
          // A saturating tick wins over a coincident start_stop or lap.
          if (tick_rise && cnt_q == CNT_MAX) begin
            state_d = FULL;
            hold_d  = 1'b0;
          end else begin
            if (tick_rise) cnt_d = bcd_inc(cnt_q);
            if (start_stop) begin
              state_d = PAUSE;
            end else if (lap) begin
              if (hold_q) begin
                hold_d = 1'b0;
              end else begin
                hold_d = 1'b1;
                lap_d  = cnt_d;
              end
            end
          end
        end
        PAUSE: begin
          if (start_stop) begin
            state_d = RUN;
          end else if (lap && hold_q) begin
            hold_d = 1'b0;
          end
        end
        FULL: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      lap_q   <= '0;
      hold_q  <= 1'b0;
      disp_q  <= '0;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_in;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      hold_q  <= hold_d;
      disp_q  <= hold_d ? lap_d : cnt_d;
      run_q   <= (state_d == RUN);
      ovf_q   <= (state_d == FULL);
    end
  end

  assign min_bcd  = disp_q[23:16];
  assign sec_bcd  = disp_q[15:8];
  assign cs_bcd   = disp_q[7:0];
  assign running  = run_q;
  assign lap_hold = hold_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: two instances (MAX_MIN=59 and 0) against a
// centisecond-integer model, plus directed literal checks.
module tb_stopwatch_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [7:0] o_min [2];
  logic [7:0] o_sec [2];
  logic [7:0] o_cs  [2];
  logic       o_run [2];
  logic       o_hold[2];
  logic       o_ovf [2];

  stopwatch_core u_dut0 (
    .clkin(clk), .rst(rst), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .min_bcd(o_min[0]), .sec_bcd(o_sec[0]), .cs_bcd(o_cs[0]),
    .running(o_run[0]), .lap_hold(o_hold[0]), .overflow(o_ovf[0])
  );

  stopwatch_core #(.MAX_MIN(0)) u_dut1 (
    .clkin(clk), .rst(rst), .tick_in(tick_in),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .min_bcd(o_min[1]), .sec_bcd(o_sec[1]), .cs_bcd(o_cs[1]),
    .running(o_run[1]), .lap_hold(o_hold[1]), .overflow(o_ovf[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0=idle 1=run 2=pause 3=full; count in centiseconds.
  int m_st  [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_hold[2] = '{0, 0};
  int m_lap [2] = '{0, 0};
  int m_max [2] = '{59 * 6000 + 5999, 5999};
  bit m_prev = 1'b0;

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [26:0] get_out(input int i);
    return {o_min[i], o_sec[i], o_cs[i], o_run[i], o_hold[i], o_ovf[i]};
  endfunction

  function automatic logic [26:0] exp_out(input int i);
    int d;
    d = (m_hold[i] != 0) ? m_lap[i] : m_cnt[i];
    return {bcd8(d / 6000), bcd8((d / 100) % 60), bcd8(d % 100),
            m_st[i] == 1, m_hold[i] != 0, m_st[i] == 3};
  endfunction

  task automatic check(input string nm, input logic [26:0] act,
                       input logic [26:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int i, input logic [7:0] mn,
                     input logic [7:0] sc, input logic [7:0] cs,
                     input bit r, input bit h, input bit o);
    check(nm, get_out(i), {mn, sc, cs, r, h, o});
  endtask

  task automatic model_step();
    bit rise;
    rise = tick_in & ~m_prev;
    if (rst) begin
      m_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_lap[i] = 0;
      end
      return;
    end
    m_prev = tick_in;
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        m_st[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_lap[i] = 0;
      end else if (m_st[i] == 0) begin
        if (start_stop) m_st[i] = 1;
      end else if (m_st[i] == 1) begin
        if (rise && m_cnt[i] == m_max[i]) begin
          m_st[i] = 3;
          m_hold[i] = 0;
        end else begin
          if (rise) m_cnt[i] = m_cnt[i] + 1;
          if (start_stop) m_st[i] = 2;
          else if (lap) begin
            if (m_hold[i] != 0) m_hold[i] = 0;
            else begin
              m_hold[i] = 1;
              m_lap[i] = m_cnt[i];
            end
          end
        end
      end else if (m_st[i] == 2) begin
        if (start_stop) m_st[i] = 1;
        else if (lap && m_hold[i] != 0) m_hold[i] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("model_dut0", get_out(0), exp_out(0));
      check("model_dut1", get_out(1), exp_out(1));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n, input int hi, input int lo);
    repeat (n) begin
      tick_in = 1'b1;
      step(hi);
      tick_in = 1'b0;
      step(lo);
    end
  endtask

  task automatic pulse(input bit ss, input bit cl, input bit lp);
    start_stop = ss;
    clear = cl;
    lap = lp;
    step(1);
    start_stop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
    step(1);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    repeat (20) begin
      tick_in = ~tick_in;
      step(2);
    end
    lit("idle_ticks", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    pulse(1, 0, 0);
    ticks(100, 4, 4);
    lit("carry_sec", 0, 8'h00, 8'h01, 8'h00, 1, 0, 0);
    ticks(5900, 4, 4);
    lit("carry_min", 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
    lit("sat_full", 1, 8'h00, 8'h59, 8'h99, 0, 0, 1);
    pulse(1, 0, 1);
    lit("sat_ignore", 1, 8'h00, 8'h59, 8'h99, 0, 0, 1);
    lit("ss_drops_lap", 0, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    pulse(0, 1, 0);
    lit("sat_clear", 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    pulse(1, 0, 0);
    ticks(37, 4, 4);
    pulse(1, 0, 0);
    ticks(50, 4, 4);
    pulse(1, 0, 0);
    ticks(5, 4, 4);
    lit("pause_resume", 0, 8'h00, 8'h00, 8'h42, 1, 0, 0);
    tick_in = 1'b1;
    step(30);
    tick_in = 1'b0;
    step(4);
    lit("held_tick", 0, 8'h00, 8'h00, 8'h43, 1, 0, 0);

    pulse(0, 1, 0);
    pulse(1, 0, 0);
    ticks(325, 4, 4);
    pulse(0, 0, 1);
    ticks(200, 4, 4);
    lit("lap_frozen", 0, 8'h00, 8'h03, 8'h25, 1, 1, 0);
    pulse(0, 0, 1);
    lit("lap_release", 0, 8'h00, 8'h05, 8'h25, 1, 0, 0);

    pulse(0, 0, 1);
    tick_in = 1'b1;
    pulse(1, 1, 1);
    tick_in = 1'b0;
    step(2);
    lit("collision", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    pulse(1, 0, 0);
    ticks(1234, 1, 1);
    lit("pre_rst", 0, 8'h00, 8'h12, 8'h34, 1, 0, 0);
    rst = 1'b1;
    step(1);
    lit("mid_rst", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    rst = 1'b0;
    step(1);

    repeat (20000) begin
      tick_in    = 1'($urandom_range(0, 1));
      start_stop = ($urandom_range(0, 39) == 0);
      lap        = ($urandom_range(0, 14) == 0);
      clear      = ($urandom_range(0, 2999) == 0);
      rst        = ($urandom_range(0, 4999) == 0);
      step(1);
    end
    tick_in = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Centisecond stopwatch that consumes the divided square wave from the clock-divider stage (configured for 100 Hz) as its count tick.
- Runs entirely in the system clock domain.
- Detects rising edges of the tick and keeps a BCD mm:ss.cc count.
- Supports start/stop, clear and lap-hold controls, and feeds BCD digits to the seven-segment display stage downstream.

Parameters:
- MAX_MIN, 59, highest minute value; saturation point is MAX_MIN:59.99. Legal range 0..99.

Ports:
- clkin  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  divided square wave from the clock divider. Only rising edges, detected in clkin domain, advance the count.
- start_stop  input  1  single-cycle pulse (debounced upstream); toggles run/pause.
- clear  input  1  single-cycle pulse; zero the count and return to IDLE.
- lap  input  1  single-cycle pulse; toggles display hold.
- min_bcd  output  8  displayed minutes, {tens, ones} BCD.
- sec_bcd  output  8  displayed seconds, BCD 00..59.
- cs_bcd  output  8  displayed centiseconds, BCD 00..99.
- running  output  1  high in RUN state.
- lap_hold  output  1  high while display is frozen.
- overflow  output  1  high in FULL state.

Behaviour:
- Reset (rst=1 at a clkin edge):
  - State goes to IDLE.
  - Internal count, lap registers and all outputs go to 0.
  - tick_d (tick_in delay register) goes to 0.
  - rst overrides every other input, including mid-count.
- Edge detect:
  - tick_d <= tick_in every cycle.
  - tick_rise = tick_in & ~tick_d.
  - A tick held high produces exactly one tick_rise.
- States: IDLE, RUN, PAUSE, FULL. Transitions are evaluated on the current state.
  - IDLE: start_stop -> RUN. Count stays 00:00.00.
  - RUN: start_stop -> PAUSE. Each tick_rise increments the count.
  - PAUSE: start_stop -> RUN. Count frozen; tick_rise ignored.
  - FULL: only clear or rst exits. start_stop and lap are ignored.
  - clear in any state -> IDLE, count zeroed, lap_hold cleared.
- Priority within one cycle: rst > clear > start_stop > lap.
  - A lap pulse coincident with start_stop is dropped.
  - A tick_rise coincident with start_stop is still counted if the current state is RUN.
  - A tick_rise coincident with start_stop is not counted if the current state is IDLE or PAUSE.
  - A tick_rise coincident with clear is discarded.
- Count arithmetic (BCD digits, each 4 bits):
  - cs ones digit 9 -> 0 with carry into cs tens; cs 99 -> 00 with carry into sec.
  - sec 59 -> 00 with carry into min.
  - All digits stay within their BCD ranges at all times.
- Saturation: a tick_rise in RUN while count == MAX_MIN:59.99 leaves the count unchanged, enters FULL and sets overflow=1. The count never wraps.
- Lap hold:
  - lap in RUN with lap_hold=0: capture the live count into the lap registers and set lap_hold=1.
  - lap with lap_hold=1, in RUN or PAUSE: clear lap_hold.
  - lap in IDLE is ignored.
  - lap in PAUSE with lap_hold=0 is ignored.
  - The live count keeps advancing while held.
  - Entering FULL forces lap_hold=0.
- Display outputs:
  - Registered: disp <= lap_hold_next ? lap_regs : count_next.
  - min_bcd, sec_bcd and cs_bcd therefore reflect a tick_rise at the same clkin edge the count changes (no extra lag beyond edge detection).
  - Latency: tick_in rising at cycle N (sampled) gives the updated display after edge N.
- running, lap_hold and overflow are registered state decodes; they update at the edge the state changes.

Test Plan:
- Reset/idle: assert rst 2 cycles, toggle tick_in 20 times with no start -> outputs 00/00/00, running=0, overflow=0.
- Count and carry: start_stop, then 100 tick rises (tick period 8 clkin cycles, 4 high) -> sec_bcd=0x01, cs_bcd=0x00. Continue to 6000 rises -> min_bcd=0x01, sec_bcd=0x00, cs_bcd=0x00.
- Pause/resume: run 37 rises, pause, 50 rises, resume, 5 rises -> cs_bcd=0x42. Tick held high 30 cycles -> only +1.
- Lap: run to 00:03.25, lap -> display frozen at 0x00/0x03/0x25 for 200 further rises. Lap again -> display 00:05.25, lap_hold=0.
- Saturation: MAX_MIN=0, run 6000 rises -> display 00:59.99, overflow=1, running=0. start_stop and lap ignored; clear -> 00:00.00, IDLE.
- Collisions: clear+start_stop+lap+tick_rise in the same cycle from RUN -> IDLE, zero count, lap_hold=0. rst asserted mid-RUN at 00:12.34 -> all outputs 0 next cycle.
